// File: rtl/pcomp_sampler_pkg.sv
// Shared definitions for the full-adder p-bit state sampler.
// Holds the sampler FSM state type, default widths and the bit positions of
// each p-bit within the packed state vector {A, B, Cin, S, Cout}.
package pcomp_sampler_pkg;

  localparam int unsigned StateWDefault = 5;
  localparam int unsigned CntWDefault   = 16;

  // Bit positions inside state_in (MSB = A).
  localparam int unsigned BitA    = 4;
  localparam int unsigned BitB    = 3;
  localparam int unsigned BitCin  = 2;
  localparam int unsigned BitS    = 1;
  localparam int unsigned BitCout = 0;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StBurn,
    StSample,
    StFin
  } sampler_state_e;

endpackage

// File: rtl/state_hist_ram.sv
// Histogram bin storage for the state sampler.
// Ports:
//   clk, reset          clock; reset only clears the rd_data register
//   wr_en/wr_addr/wr_data  synchronous write port (clear and increment)
//   upd_addr -> upd_data   synchronous read port feeding the increment path
//   rd_addr  -> rd_data    synchronous read port for external readout
// Reads return the contents before any write on the same edge.
module state_hist_ram #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [DataW-1:0] wr_data,
  input  logic [AddrW-1:0] upd_addr,
  output logic [DataW-1:0] upd_data,
  input  logic [AddrW-1:0] rd_addr,
  output logic [DataW-1:0] rd_data
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    upd_data <= mem[upd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fa_state_sampler.sv
// Full-adder p-bit state sampler: clears a histogram, waits a burn-in period,
// then samples the registered p-bit state every interval+1 cycles and counts
// occurrences per state in saturating bins.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 run request, honoured only when idle
//   num_samples, burn_in, interval  run parameters, latched on accepted start
//   state_in              packed p-bit state {A,B,Cin,S,Cout}
//   busy, done, sat       status; done is a one-cycle pulse, sat is sticky
//   rd_addr -> rd_data    bin readout, one-cycle latency, valid when idle
//   samples_taken         samples taken in the current or last run
module fa_state_sampler
  import pcomp_sampler_pkg::*;
#(
  parameter int unsigned STATE_W = StateWDefault,
  parameter int unsigned CNT_W   = CntWDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        num_samples,
  input  logic [7:0]         burn_in,
  input  logic [3:0]         interval,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic               done,
  output logic               sat,
  input  logic [STATE_W-1:0] rd_addr,
  output logic [CNT_W-1:0]   rd_data,
  output logic [15:0]        samples_taken
);

  localparam logic [CNT_W-1:0]   CntMax  = {CNT_W{1'b1}};
  localparam logic [STATE_W-1:0] AddrMax = {STATE_W{1'b1}};

  sampler_state_e     st_q;
  logic [15:0]        num_q, taken_q;
  logic [7:0]         burn_cnt_q;
  logic [3:0]         intv_q, gap_q;
  logic [STATE_W-1:0] clr_addr_q, state_q;
  logic               done_q, sat_q;

  // Increment pipeline: stage 2 holds the sample whose bin read is returning.
  logic               s2_valid_q;
  logic [STATE_W-1:0] s2_addr_q;
  // Last write, used to bypass the read-during-write on back-to-back samples.
  logic               lw_valid_q;
  logic [STATE_W-1:0] lw_addr_q;
  logic [CNT_W-1:0]   lw_data_q;

  logic [CNT_W-1:0]   upd_data, cur_cnt, wr_data;
  logic [STATE_W-1:0] wr_addr;
  logic               wr_en, blocked, sample_fire;

  assign sample_fire = (st_q == StSample) && (gap_q == 4'd0);

  always_comb begin
    cur_cnt = (lw_valid_q && (lw_addr_q == s2_addr_q)) ? lw_data_q : upd_data;
    blocked = s2_valid_q && (cur_cnt == CntMax);
    wr_en   = 1'b0;
    wr_addr = clr_addr_q;
    wr_data = '0;
    if (st_q == StClear) begin
      wr_en = 1'b1;
    end else if (s2_valid_q) begin
      wr_en   = 1'b1;
      wr_addr = s2_addr_q;
      wr_data = blocked ? cur_cnt : cur_cnt + CNT_W'(1);
    end
  end

  state_hist_ram #(
    .AddrW(STATE_W),
    .DataW(CNT_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .upd_addr(state_q),
    .upd_data(upd_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Input register for the asynchronous p-bit state.
  always_ff @(posedge clk) begin
    state_q <= state_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= StIdle;
      num_q      <= '0;
      taken_q    <= '0;
      burn_cnt_q <= '0;
      intv_q     <= '0;
      gap_q      <= '0;
      clr_addr_q <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      lw_valid_q <= 1'b0;
      lw_addr_q  <= '0;
      lw_data_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      s2_valid_q <= sample_fire;
      s2_addr_q  <= state_q;
      lw_valid_q <= wr_en;
      lw_addr_q  <= wr_addr;
      lw_data_q  <= wr_data;
      if (blocked) begin
        sat_q <= 1'b1;
      end
      unique case (st_q)
        StIdle: begin
          if (start) begin
            num_q      <= num_samples;
            burn_cnt_q <= burn_in;
            intv_q     <= interval;
            taken_q    <= '0;
            sat_q      <= 1'b0;
            clr_addr_q <= '0;
            st_q       <= StClear;
          end
        end
        StClear: begin
          clr_addr_q <= clr_addr_q + STATE_W'(1);
          gap_q      <= 4'd0;
          if (clr_addr_q == AddrMax) begin
            if (burn_cnt_q != 8'd0) begin
              st_q <= StBurn;
            end else begin
              st_q <= (num_q == 16'd0) ? StFin : StSample;
            end
          end
        end
        StBurn: begin
          burn_cnt_q <= burn_cnt_q - 8'd1;
          if (burn_cnt_q == 8'd1) begin
            st_q <= (num_q == 16'd0) ? StFin : StSample;
          end
        end
        StSample: begin
          if (sample_fire) begin
            taken_q <= taken_q + 16'd1;
            gap_q   <= intv_q;
            if ((taken_q + 16'd1) == num_q) begin
              st_q <= StFin;
            end
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        StFin: begin
          done_q <= 1'b1;
          st_q   <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign busy          = (st_q != StIdle);
  assign done          = done_q;
  assign sat           = sat_q;
  assign samples_taken = taken_q;

endmodule
